// File: rtl/rom_arb_pkg.sv
// ============================================================================
//  Module      : rom_arb_pkg
//  Description : Shared constants and the access-check helper for the
//                ROM arbiter (and any future memory arbiter).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_arb_pkg;

   localparam int PORT_FETCH         = 0;
   localparam int PORT_LOAD          = 1;
   localparam int NUM_PORTS          = 2;
   localparam int DEFAULT_ADDR_WIDTH = 12;

   // A word access is bad if it is not 4-byte aligned or lies above the
   // top byte of a 2**aw word memory.
   function automatic logic addr_err(input logic [31:0] addr, input int aw);
      logic misaligned;
      logic out_of_range;
      misaligned   = (addr[1:0] != 2'b00);
      out_of_range = ((addr >> (aw + 2)) != 32'd0);
      return misaligned | out_of_range;
   endfunction

endpackage : rom_arb_pkg

`default_nettype wire

// File: rtl/rom_arb_resp_slot.sv
// ============================================================================
//  Module      : rom_arb_resp_slot
//  Description : One-entry response register with valid/ready handshake and
//                a load strobe; a load wins over a same-cycle consume.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arb_resp_slot (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic [31:0] data_i,
   input  logic        err_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] data_o,
   output logic        err_o
);

   logic        valid_q, valid_d;
   logic [31:0] data_q,  data_d;
   logic        err_q,   err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      err_d   = err_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         err_d   = err_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign err_o   = err_q;

endmodule : rom_arb_resp_slot

`default_nettype wire

// File: rtl/rom_arbiter.sv
// ============================================================================
//  Module      : rom_arbiter
//  Description : Round-robin arbiter sharing one combinational instruction ROM
//                between the fetch unit (port 0) and the load unit (port 1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        p0_req_valid,
   input  logic [31:0] p0_req_addr,
   output logic        p0_req_ready,
   output logic        p0_resp_valid,
   output logic [31:0] p0_resp_data,
   output logic        p0_resp_err,
   input  logic        p0_resp_ready,

   input  logic        p1_req_valid,
   input  logic [31:0] p1_req_addr,
   output logic        p1_req_ready,
   output logic        p1_resp_valid,
   output logic [31:0] p1_resp_data,
   output logic        p1_resp_err,
   input  logic        p1_resp_ready,

   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data
);

   logic [NUM_PORTS-1:0] w_req_valid;
   logic [NUM_PORTS-1:0] w_resp_ready;
   logic [NUM_PORTS-1:0] w_resp_valid;
   logic [NUM_PORTS-1:0] w_resp_err;
   logic [NUM_PORTS-1:0] w_elig;
   logic [NUM_PORTS-1:0] w_grant;
   logic [31:0]          w_req_addr  [NUM_PORTS];
   logic [31:0]          w_resp_data [NUM_PORTS];
   logic [31:0]          w_rom_addr;
   logic [31:0]          w_load_data;
   logic                 w_load_err;

   // Records the most recently granted port; reset favours fetch next.
   logic last_grant_q, last_grant_d;

   assign w_req_valid[PORT_FETCH]  = p0_req_valid;
   assign w_req_valid[PORT_LOAD]   = p1_req_valid;
   assign w_resp_ready[PORT_FETCH] = p0_resp_ready;
   assign w_resp_ready[PORT_LOAD]  = p1_resp_ready;
   assign w_req_addr[PORT_FETCH]   = p0_req_addr;
   assign w_req_addr[PORT_LOAD]    = p1_req_addr;

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_elig[i] = w_req_valid[i] & (~w_resp_valid[i] | w_resp_ready[i]) & ~rst;
      end
   end

   always_comb begin
      w_grant = '0;
      if (&w_elig) begin
         if (last_grant_q == 1'(PORT_LOAD)) begin
            w_grant[PORT_FETCH] = 1'b1;
         end else begin
            w_grant[PORT_LOAD] = 1'b1;
         end
      end else begin
         w_grant = w_elig;
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (w_grant[PORT_FETCH]) begin
         last_grant_d = 1'(PORT_FETCH);
      end else if (w_grant[PORT_LOAD]) begin
         last_grant_d = 1'(PORT_LOAD);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'(PORT_LOAD);
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      w_rom_addr = 32'd0;
      if (w_grant[PORT_FETCH]) begin
         w_rom_addr = w_req_addr[PORT_FETCH];
      end else if (w_grant[PORT_LOAD]) begin
         w_rom_addr = w_req_addr[PORT_LOAD];
      end
   end

   assign w_load_err  = addr_err(w_rom_addr, ADDR_WIDTH);
   assign w_load_data = w_load_err ? 32'd0 : rom_data;

   generate
      for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
         rom_arb_resp_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .load_i  (w_grant[i]),
            .data_i  (w_load_data),
            .err_i   (w_load_err),
            .ready_i (w_resp_ready[i]),
            .valid_o (w_resp_valid[i]),
            .data_o  (w_resp_data[i]),
            .err_o   (w_resp_err[i])
         );
      end
   endgenerate

   assign rom_addr      = w_rom_addr;
   assign p0_req_ready  = w_grant[PORT_FETCH];
   assign p1_req_ready  = w_grant[PORT_LOAD];
   assign p0_resp_valid = w_resp_valid[PORT_FETCH];
   assign p1_resp_valid = w_resp_valid[PORT_LOAD];
   assign p0_resp_data  = w_resp_data[PORT_FETCH];
   assign p1_resp_data  = w_resp_data[PORT_LOAD];
   assign p0_resp_err   = w_resp_err[PORT_FETCH];
   assign p1_resp_err   = w_resp_err[PORT_LOAD];

endmodule : rom_arbiter

`default_nettype wire

// File: doc/rom_arbiter.md
# rom_arbiter

Two-requester arbiter that shares the single, combinationally read, word-addressed instruction ROM between the instruction-fetch unit (port 0) and the load unit (port 1, for constant and rodata reads). It accepts at most one request per cycle, granting round-robin when both ports contend. It drives the ROM address and captures the ROM word into a per-port response register, which holds it until the requester takes it. It also flags misaligned or out-of-range accesses.

## Interface
Parameters:
- ADDR_WIDTH, 12, ROM word-index width; ROM holds 2**ADDR_WIDTH 32-bit words, byte range 0 .. 2**(ADDR_WIDTH+2)-1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- p0_req_valid  in  1  fetch request valid.
- p0_req_addr  in  32  fetch byte address.
- p0_req_ready  out  1  fetch request accepted this cycle.
- p0_resp_valid  out  1  fetch response held.
- p0_resp_data  out  32  fetch response word.
- p0_resp_err  out  1  fetch access misaligned or out of range.
- p0_resp_ready  in  1  fetch unit consumes the response.
- p1_req_valid, p1_req_addr, p1_req_ready, p1_resp_valid, p1_resp_data, p1_resp_err, p1_resp_ready: same as the p0 ports, for the load unit.
- rom_addr  out  32  byte address to the ROM; the ROM uses bits [ADDR_WIDTH+1:2].
- rom_data  in  32  ROM read data, combinational from rom_addr.

## Operation
- A port is eligible when req_valid=1 and its response slot is free. A slot is free when resp_valid=0, or when resp_valid=1 and resp_ready=1 in the same cycle.
- Grant rules:
  - One eligible port: it is granted.
  - Both eligible: grant goes to the port not recorded in last_grant.
  - Neither eligible: no grant.
- last_grant updates only on a grant.
- req_ready equals grant for that port and is combinational. Both req_ready outputs are forced to 0 while rst=1.
- rom_addr equals the granted port's req_addr, or 32'h0 when there is no grant.
- Error check on the granted address:
  - err=1 when addr[1:0]!=0, or when addr[31:ADDR_WIDTH+2]!=0.
  - On error, the captured data is 32'h0 and err=1; otherwise data is rom_data and err=0.
- Response slot (per port):
  - On grant: resp_valid<=1, and data/err are loaded.
  - Else, if resp_ready=1 and resp_valid=1: resp_valid<=0.
  - Data and err are stable while resp_valid=1 and resp_ready=0.
- resp_ready asserted while resp_valid=0 is ignored.
- A requester may drop req_valid or change req_addr at any time before it is granted. The arbiter imposes no stickiness.

## Timing
- Reset values:
  - p0_resp_valid=0, p1_resp_valid=0.
  - resp_data=0 and resp_err=0 on both ports.
  - last_grant=1, so port 0 wins the first contention.
- Latency: request accepted at edge N, response visible (resp_valid=1) after edge N, i.e. in cycle N+1.
- Throughput: a single port with resp_ready held at 1 sustains one access per cycle. Under full contention each port gets one access every 2 cycles.
- Backpressure: while a port's slot is occupied and resp_ready=0, that port is not eligible. The other port may take every cycle meanwhile.
- Simultaneous consume and grant on the same port in the same cycle: the slot reloads with the new response and resp_valid stays 1.
- Reset mid-operation: pending responses are dropped (resp_valid<=0) and last_grant<=1. No request is accepted in a cycle with rst=1.

## Structure
- Package rom_arb_pkg holds:
  - the port index constants PORT_FETCH=0 and PORT_LOAD=1;
  - the default ADDR_WIDTH constant;
  - a function for the misalign/range check, shared with any future RAM arbiter.
- Sub-module rom_arb_resp_slot: a one-entry response register with valid/ready and a load strobe. It is instantiated once per port.
- The arbiter core, last_grant register and ROM address mux live in rom_arbiter.

## Test plan
- Reset then idle: after rst deasserts, all resp_valid=0, rom_addr=0 and both req_ready=0 with no valid requests.
- Single port streaming:
  - Stimulus: p0 requests 0x0, 0x4, 0x8 on back-to-back cycles with resp_ready=1.
  - Required: req_ready=1 each cycle; resp_data equals mem[0], mem[1], mem[2] one cycle later each; err=0.
- Contention:
  - Stimulus: both ports valid continuously from reset, p0 at 0x10, p1 at 0x20.
  - Required: grants alternate p0, p1, p0, p1, and each port sees resp_valid every other cycle.
- Backpressure:
  - Stimulus: p1 with resp_ready=0 for 3 cycles after its first response.
  - Required: p1_req_ready=0 during the stall, p1_resp_data held stable, p0 granted every cycle; p1 is granted again in the cycle resp_ready returns to 1.
- Errors:
  - Stimulus: p0 requests 0x6 (misaligned); p1 requests 0x4000 with ADDR_WIDTH=12 (out of range).
  - Required: both responses show err=1 and data=0. A following request to 0x3FFC returns mem[4095] with err=0.
- Reset mid-operation:
  - Stimulus: assert rst while both slots hold unconsumed responses.
  - Required: both resp_valid=0 on the next cycle; the first contention after reset grants p0.
